// File: rtl/div_bcd_conv.sv
// Binary-to-packed-BCD converter behind the sequential divider.
// Double-dabble, one bit per clock; divide-by-zero is reported as err with a blanked readout.
module div_bcd_conv #(
    parameter int SIZE     = 16,
    parameter int LG2_SIZE = 4,
    parameter int DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SIZE-1:0]       bin_in,
    input  logic                  ovf_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err
);

    localparam int BW = 4 * DIGITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [LG2_SIZE:0] CNT_INIT = (LG2_SIZE + 1)'(SIZE);
    localparam logic [LG2_SIZE:0] CNT_LAST = (LG2_SIZE + 1)'(1);

    // Digits are corrected independently; no carry ever crosses a digit boundary.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    logic [1:0]           state;
    logic [SIZE-1:0]      bin_sr;
    logic [BW-1:0]        acc;
    logic [LG2_SIZE:0]    cnt;
    logic [BW-1:0]        bcd_next;
    logic                 err_next;
    logic [BW+SIZE-1:0]   cat_next;

    always_comb begin
        cat_next = {add3(acc), bin_sr} << 1;
    end

    assign busy = (state == SHIFT) || (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bin_sr   <= '0;
            acc      <= '0;
            cnt      <= '0;
            bcd_next <= '0;
            err_next <= 1'b0;
            bcd_out  <= '0;
            err      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ovf_in) begin
                            bcd_next <= '1;
                            err_next <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bin_sr <= bin_in;
                            acc    <= '0;
                            cnt    <= CNT_INIT;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc    <= cat_next[BW+SIZE-1:SIZE];
                    bin_sr <= cat_next[SIZE-1:0];
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        bcd_next <= cat_next[BW+SIZE-1:SIZE];
                        err_next <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bcd_out <= bcd_next;
                    err     <= err_next;
                    valid   <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Scenario bench for div_bcd_conv: expected {err, bcd} queued at start, compared at valid.
module tb_div_bcd_conv;

    localparam int SIZE   = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic            clk;
    logic            reset;
    logic            start;
    logic [SIZE-1:0] bin_in;
    logic            ovf_in;
    logic            busy;
    logic            valid;
    logic [BW-1:0]   bcd_out;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    logic [BW:0] exp_q[$];

    div_bcd_conv #(.SIZE(SIZE), .LG2_SIZE(4), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .ovf_in(ovf_in),
        .busy(busy), .valid(valid), .bcd_out(bcd_out), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) n_valid++;

    // Reference model: decimal digits by repeated division.
    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Drives start for one edge (edge 0) and leaves time at edge0+1.
    task automatic issue(input logic [SIZE-1:0] v, input logic ovf, input bit expect_out);
        start  = 1'b1;
        bin_in = v;
        ovf_in = ovf;
        if (expect_out) exp_q.push_back(ovf ? {1'b1, {BW{1'b1}}} : {1'b0, to_bcd(v)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the edge index after which valid rose (-1 on timeout) and busy-high cycle count.
    task automatic wait_valid(input string name, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (valid === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no valid within 60 cycles", name);
        end
    endtask

    task automatic check_out(input string name);
        logic [BW:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: valid with empty scoreboard, got err=%b bcd=%h", name, err, bcd_out);
        end else begin
            e = exp_q.pop_front();
            if ({err, bcd_out} !== e) begin
                n_fail++;
                $display("FAIL %s: got err=%b bcd=%h, expected err=%b bcd=%h",
                         name, err, bcd_out, e[BW], e[BW-1:0]);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic convert(input string name, input logic [SIZE-1:0] v, input logic ovf);
        int lat, bc;
        issue(v, ovf, 1'b1);
        wait_valid(name, lat, bc);
        if (lat >= 0) begin
            check_out(name);
            check_int({name, "_latency"}, lat, ovf ? 1 : SIZE + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, valid, err, bcd_out} !== {3'b000, {BW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b err=%b bcd=%h, expected all 0",
                     busy, valid, err, bcd_out);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        convert("zero", 16'd0, 1'b0);
    endtask

    task automatic test_max();
        int lat, bc;
        issue(16'd65535, 1'b0, 1'b1);
        wait_valid("max", lat, bc);
        if (lat >= 0) begin
            check_out("max");
            check_int("max_busy_cycles", bc, SIZE + 1);
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL max_valid_width: valid=%b one cycle later, expected 0", valid);
            end
        end
    endtask

    task automatic test_capture();
        int lat, bc;
        issue(16'd12345, 1'b0, 1'b1);
        bin_in = 16'd999;
        ovf_in = 1'b1;
        wait_valid("capture", lat, bc);
        if (lat >= 0) check_out("capture");
        ovf_in = 1'b0;
        @(posedge clk); #1;
        convert("nine", 16'd9, 1'b0);
    endtask

    task automatic test_overflow();
        convert("ovf", 16'd77, 1'b1);
        @(posedge clk); #1;
        convert("after_ovf", 16'd42, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, bc, v0;
        v0 = n_valid;
        issue(16'd100, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        issue(16'd555, 1'b0, 1'b0);
        wait_valid("ignored_start", lat, bc);
        if (lat >= 0) check_out("ignored_start");
        repeat (25) @(posedge clk);
        #1;
        check_int("ignored_start_pulses", n_valid - v0, 1);
    endtask

    task automatic test_abort();
        int v0;
        issue(16'd4321, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        v0 = n_valid;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, valid, err, bcd_out} !== {3'b000, {BW{1'b0}}}) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b valid=%b err=%b bcd=%h, expected all 0",
                     busy, valid, err, bcd_out);
        end
        repeat (25) @(posedge clk);
        #1;
        check_int("abort_no_valid", n_valid - v0, 0);
        convert("after_abort", 16'd4321, 1'b0);
    endtask

    task automatic test_random();
        logic [SIZE-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = SIZE'($urandom_range(0, 65535));
            @(posedge clk); #1;
            convert("random", v, 1'b0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        ovf_in = 1'b0;
        #1;
        test_reset();
        test_zero();
        @(posedge clk); #1;
        test_max();
        @(posedge clk); #1;
        test_capture();
        @(posedge clk); #1;
        test_overflow();
        @(posedge clk); #1;
        test_back_to_back();
        test_abort();
        test_random();
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
